adder_receiver: RTL and testbench

- Responder end of the client-to-adder AXI-Stream link.
- Accepts beats on the axis_adder_interface_* slave port into an input FIFO.
- Accumulates each transaction's operands, from first beat through the tlast beat, into a wrap-around sum.
- Presents each transaction's sum on a valid/ready response port back toward the client side.

---
 rtl/adder_receiver.sv | 142 ++++++++++++++
 tb/tb_adder_receiver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_receiver.sv
// adder_receiver: responder end of the client-to-adder AXI-Stream link.
// Incoming beats are buffered in a FIFO. An accumulate/respond FSM pops one
// entry per cycle and sums the operands of each transaction, up to and
// including its tlast beat. The sum wraps modulo 2^DATAW. Each transaction's
// sum is presented on a valid/ready response port.
// Optional build macro: ADDER_RECEIVER_OVERFLOW_EN adds the response_overflow
// port. That port carries a sticky carry-out flag for each transaction.
module adder_receiver #(
  parameter int DATAW      = 128,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axis_adder_interface_tvalid,
  input  logic             axis_adder_interface_tlast,
  input  logic [DATAW-1:0] axis_adder_interface_tdata,
  output logic             axis_adder_interface_tready,
  input  logic             response_ready,
  output logic             response_valid,
  output logic [DATAW-1:0] response_data
`ifdef ADDER_RECEIVER_OVERFLOW_EN
  ,
  output logic             response_overflow
`endif
);

  localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic {ACCUM, RESP} state_t;

  // Each FIFO entry holds {last, data}.
  logic [DATAW:0]   mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  state_t             state;
  logic [DATAW-1:0]   acc;

  logic               push;
  logic               pop;
  logic [DATAW-1:0]   entry_data;
  logic               entry_last;
  logic [DATAW-1:0]   sum_next;

  // Modulo 2^DATAW sum; the carry out is dropped.
  function automatic logic [DATAW-1:0] add_wrap(input logic [DATAW-1:0] a,
                                                input logic [DATAW-1:0] b);
    return a + b;
  endfunction

`ifdef ADDER_RECEIVER_OVERFLOW_EN
  logic carry_flag;
  logic carry_now;

  // Carry out of bit DATAW-1 for the same addition add_wrap performs.
  function automatic logic carry_out(input logic [DATAW-1:0] a,
                                     input logic [DATAW-1:0] b);
    logic [DATAW:0] full;
    full = {1'b0, a} + {1'b0, b};
    return full[DATAW];
  endfunction

  assign carry_now = carry_out(acc, entry_data);
`endif

  // Ready depends only on the registered occupancy, never on tvalid.
  assign axis_adder_interface_tready = (count != DEPTH_CNT);
  assign push       = axis_adder_interface_tvalid && axis_adder_interface_tready;
  assign pop        = (state == ACCUM) && (count != '0);
  assign entry_data = mem[rd_ptr][DATAW-1:0];
  assign entry_last = mem[rd_ptr][DATAW];
  assign sum_next   = add_wrap(acc, entry_data);

  // FIFO storage write; the contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {axis_adder_interface_tlast, axis_adder_interface_tdata};
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Accumulate/respond FSM. RESP holds the sum until the handshake, then returns to ACCUM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ACCUM;
      acc            <= '0;
      response_valid <= 1'b0;
      response_data  <= '0;
`ifdef ADDER_RECEIVER_OVERFLOW_EN
      carry_flag        <= 1'b0;
      response_overflow <= 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (pop) begin
            if (entry_last) begin
              response_data  <= sum_next;
              response_valid <= 1'b1;
              acc            <= '0;
              state          <= RESP;
`ifdef ADDER_RECEIVER_OVERFLOW_EN
              response_overflow <= carry_flag | carry_now;
              carry_flag        <= 1'b0;
`endif
            end else begin
              acc <= sum_next;
`ifdef ADDER_RECEIVER_OVERFLOW_EN
              carry_flag <= carry_flag | carry_now;
`endif
            end
          end
        end
        RESP: begin
          if (response_ready) begin
            response_valid <= 1'b0;
            state          <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_receiver.sv
// tb_adder_receiver: table-driven vectors plus hand-written sequences for
// adder_receiver. Expected sums are queued when the stimulus is driven. They
// are compared when the response handshake completes.
`timescale 1ns/1ps
module tb_adder_receiver;

  localparam int DATAW = 128;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tvalid = 1'b0;
  logic             tlast = 1'b0;
  logic [DATAW-1:0] tdata = '0;
  logic             tready;
  logic             response_ready = 1'b1;
  logic             response_valid;
  logic [DATAW-1:0] response_data;
`ifdef ADDER_RECEIVER_OVERFLOW_EN
  logic             response_overflow;
`endif

  adder_receiver #(.DATAW(DATAW), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .axis_adder_interface_tvalid (tvalid),
    .axis_adder_interface_tlast  (tlast),
    .axis_adder_interface_tdata  (tdata),
    .axis_adder_interface_tready (tready),
    .response_ready              (response_ready),
    .response_valid              (response_valid),
    .response_data               (response_data)
`ifdef ADDER_RECEIVER_OVERFLOW_EN
    ,
    .response_overflow           (response_overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATAW-1:0] data;
    bit               last;
    logic [DATAW-1:0] exp_sum;
    bit               exp_ovf;
  } vec_t;

  typedef struct {
    logic [DATAW-1:0] sum;
    bit               ovf;
  } exp_t;

  vec_t vecs[12];
  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [DATAW-1:0] act,
                       input logic [DATAW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [DATAW-1:0] s, input bit o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    q.push_back(e);
  endtask

  task automatic set_vec(input int i, input logic [DATAW-1:0] d, input bit l,
                         input logic [DATAW-1:0] s, input bit o);
    vecs[i].data    = d;
    vecs[i].last    = l;
    vecs[i].exp_sum = s;
    vecs[i].exp_ovf = o;
  endtask

  // Called at posedge+1. Holds the beat until it is accepted and leaves tvalid asserted.
  task automatic send_beat(input logic [DATAW-1:0] d, input bit l);
    int n;
    n = 0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    @(negedge clk);
    while (!tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!tready) begin
      fails++;
      tests++;
      $display("FAIL send_timeout: tready stuck at 0, expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  // Wait, bounded, until all expected responses have been seen.
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || response_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, DATAW'(q.size()), '0);
  endtask

  // Scoreboard: a handshake at the coming posedge pops and compares one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && response_valid && response_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_response: got %0h, expected no response", response_data);
      end else begin
        e = q.pop_front();
        check("response_data", response_data, e.sum);
`ifdef ADDER_RECEIVER_OVERFLOW_EN
        check("response_overflow", DATAW'(response_overflow), DATAW'(e.ovf));
`endif
      end
    end
  end

  initial begin
    int accepted;
    logic [DATAW-1:0] ones;
    logic [DATAW-1:0] msb;
    ones = '1;
    msb  = '0;
    msb[DATAW-1] = 1'b1;

    set_vec(0,  128'd0,  1'b1, 128'd0,  1'b0);
    set_vec(1,  128'd1,  1'b0, 128'd0,  1'b0);
    set_vec(2,  128'd2,  1'b0, 128'd0,  1'b0);
    set_vec(3,  128'd3,  1'b1, 128'd6,  1'b0);
    set_vec(4,  ones,    1'b0, 128'd0,  1'b0);
    set_vec(5,  128'd2,  1'b1, 128'd1,  1'b1);
    set_vec(6,  128'd10, 1'b1, 128'd10, 1'b0);
    set_vec(7,  128'd20, 1'b1, 128'd20, 1'b0);
    set_vec(8,  msb,     1'b0, 128'd0,  1'b0);
    set_vec(9,  msb,     1'b1, 128'd0,  1'b1);
    set_vec(10, ones,    1'b1, ones,    1'b0);
    set_vec(11, 128'd42, 1'b1, 128'd42, 1'b0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_tready", DATAW'(tready), DATAW'(1));
    check("reset_valid", DATAW'(response_valid), '0);
    check("reset_data", response_data, '0);

    // Single-beat latency: accepted at edge N, valid for exactly cycle N+1..N+2.
    @(posedge clk);
    #1;
    push_exp(128'd5, 1'b0);
    tdata = 128'd5; tlast = 1'b1; tvalid = 1'b1;
    @(posedge clk);
    #1 tvalid = 1'b0;
    @(negedge clk);
    check("latency_valid_n", DATAW'(response_valid), '0);
    @(negedge clk);
    check("latency_valid_n1", DATAW'(response_valid), DATAW'(1));
    @(negedge clk);
    check("latency_valid_pulse", DATAW'(response_valid), '0);
    wait_drain("single_drain");

    // Table vectors with tvalid held continuously between beats.
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].last) push_exp(vecs[i].exp_sum, vecs[i].exp_ovf);
      send_beat(vecs[i].data, vecs[i].last);
    end
    tvalid = 1'b0;
    wait_drain("table_drain");

    // Backpressure: hold the response and overrun the FIFO.
    @(posedge clk);
    #1 response_ready = 1'b0;
    push_exp(128'd9, 1'b0);
    send_beat(128'd9, 1'b1);
    tvalid = 1'b0;
    for (int n = 0; n < 20 && !response_valid; n++) @(negedge clk);
    @(posedge clk);
    #1;
    accepted = 0;
    tvalid = 1'b1;
    tlast  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tdata = DATAW'(100 + i);
      @(negedge clk);
      check("bp_data_stable", response_data, 128'd9);
      check("bp_valid_stable", DATAW'(response_valid), DATAW'(1));
      if (tready) begin
        accepted++;
        push_exp(DATAW'(100 + i), 1'b0);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("bp_accepted", DATAW'(accepted), DATAW'(16));
    check("bp_tready_full", DATAW'(tready), '0);
    @(posedge clk);
    #1 tvalid = 1'b0;
    response_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_tready_after", DATAW'(tready), DATAW'(1));

    // Reset mid-transaction discards the partial sum.
    @(posedge clk);
    #1;
    send_beat(128'd7, 1'b0);
    send_beat(128'd8, 1'b0);
    tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_tready", DATAW'(tready), DATAW'(1));
    check("midrst_valid", DATAW'(response_valid), '0);
    @(posedge clk);
    #1;
    push_exp(128'd4, 1'b0);
    send_beat(128'd4, 1'b1);
    tvalid = 1'b0;
    wait_drain("midrst_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
